// File: rtl/bus_cycle_ctrl_if.sv
// Bus cycle controller handshake bundle.
// Core request side plus the multiplexed AD/A_HI pin side.
interface bus_cycle_ctrl_if;
  logic        req;
  logic        wr;
  logic        io;
  logic [15:0] address;
  logic [7:0]  wdata;
  logic        ready;
  logic [7:0]  ad_in;
  logic [7:0]  ad_out;
  logic        ad_oe;
  logic [7:0]  a_hi;
  logic        ale;
  logic        rd_n;
  logic        wr_n;
  logic        io_m;
  logic        busy;
  logic        done;
  logic        err;
  logic [7:0]  rdata;

  modport master (
    input  req,
    input  wr,
    input  io,
    input  address,
    input  wdata,
    input  ready,
    input  ad_in,
    output ad_out,
    output ad_oe,
    output a_hi,
    output ale,
    output rd_n,
    output wr_n,
    output io_m,
    output busy,
    output done,
    output err,
    output rdata
  );

  modport slave (
    output req,
    output wr,
    output io,
    output address,
    output wdata,
    output ready,
    output ad_in,
    input  ad_out,
    input  ad_oe,
    input  a_hi,
    input  ale,
    input  rd_n,
    input  wr_n,
    input  io_m,
    input  busy,
    input  done,
    input  err,
    input  rdata
  );
endinterface

// File: rtl/bus_cycle_ctrl.sv
// Multiplexed-bus cycle sequencer: T1/T2/TW/T3 with
// wait-state insertion and wait timeout abort.
module bus_cycle_ctrl #(
  parameter int unsigned MAX_WAIT = 16
) (
  input logic             clk,
  input logic             rst,
  bus_cycle_ctrl_if.master bus
);

  localparam logic [7:0] WMAX = 8'(MAX_WAIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_T1,
    S_T2,
    S_TW,
    S_T3
  } state_t;

  state_t     state;
  logic       wr_q;
  logic [7:0] wdata_q;
  logic [7:0] wcnt;
  logic [7:0] ad_out_q;
  logic       ad_oe_q;
  logic [7:0] a_hi_q;
  logic       ale_q;
  logic       rd_n_q;
  logic       wr_n_q;
  logic       io_m_q;
  logic       busy_q;
  logic       done_q;
  logic       err_q;
  logic [7:0] rdata_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      wr_q     <= 1'b0;
      wdata_q  <= 8'h00;
      wcnt     <= 8'h00;
      ad_out_q <= 8'h00;
      ad_oe_q  <= 1'b0;
      a_hi_q   <= 8'h00;
      ale_q    <= 1'b0;
      rd_n_q   <= 1'b1;
      wr_n_q   <= 1'b1;
      io_m_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= 8'h00;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (bus.req) begin
            state    <= S_T1;
            wr_q     <= bus.wr;
            wdata_q  <= bus.wdata;
            io_m_q   <= bus.io;
            a_hi_q   <= bus.address[15:8];
            ad_out_q <= bus.address[7:0];
            ad_oe_q  <= 1'b1;
            ale_q    <= 1'b1;
            busy_q   <= 1'b1;
            wcnt     <= 8'h00;
          end
        end
        S_T1: begin
          state <= S_T2;
          ale_q <= 1'b0;
          wcnt  <= 8'h00;
          if (wr_q) begin
            ad_oe_q  <= 1'b1;
            ad_out_q <= wdata_q;
            wr_n_q   <= 1'b0;
          end else begin
            ad_oe_q <= 1'b0;
            rd_n_q  <= 1'b0;
          end
        end
        S_T2: begin
          if (bus.ready) begin
            state <= S_T3;
          end else begin
            state <= S_TW;
            wcnt  <= wcnt + 8'd1;
          end
        end
        S_TW: begin
          if (bus.ready) begin
            state <= S_T3;
          end else if (wcnt == WMAX) begin
            // Device never answered: drop strobes, no data.
            state   <= S_IDLE;
            err_q   <= 1'b1;
            rd_n_q  <= 1'b1;
            wr_n_q  <= 1'b1;
            ad_oe_q <= 1'b0;
            busy_q  <= 1'b0;
          end else begin
            wcnt <= wcnt + 8'd1;
          end
        end
        S_T3: begin
          state   <= S_IDLE;
          done_q  <= 1'b1;
          rd_n_q  <= 1'b1;
          wr_n_q  <= 1'b1;
          ad_oe_q <= 1'b0;
          busy_q  <= 1'b0;
          if (!wr_q) rdata_q <= bus.ad_in;
        end
        default: begin
          state   <= S_IDLE;
          rd_n_q  <= 1'b1;
          wr_n_q  <= 1'b1;
          ad_oe_q <= 1'b0;
          ale_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ad_out = ad_out_q;
  assign bus.ad_oe  = ad_oe_q;
  assign bus.a_hi   = a_hi_q;
  assign bus.ale    = ale_q;
  assign bus.rd_n   = rd_n_q;
  assign bus.wr_n   = wr_n_q;
  assign bus.io_m   = io_m_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.err    = err_q;
  assign bus.rdata  = rdata_q;

endmodule
